mem_port_arbiter: RTL and testbench

// Shares one single-port, fixed-latency memory between the fetch stage (I-side) and the

---
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch (I) and memory stage (D): D-priority with an
// I starvation limit, one access in flight, fixed-latency read return with done pulses.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fetch_stall,
    output logic              mem_stall,
    output logic              err
);

    localparam int                CNT_W      = 4;
    localparam int                SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  LAT_INIT   = CNT_W'(MEM_LAT);
    localparam logic [SC_W-1:0]   STARVE_TOP = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  lat_cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic              grant_i, grant_d, finish;
    req_t              win;

    // Arbitration happens only in IDLE, which includes the done cycle of the previous access.
    always_comb begin
        state_nxt  = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        win.wr     = d_wr;
        win.addr   = d_addr;
        win.wdata  = d_wdata;
        case (state)
            IDLE: begin
                if (d_req && !(i_req && starve_cnt == STARVE_TOP)) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (i_req) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                    win.wr    = 1'b0;
                    win.addr  = i_addr;
                    win.wdata = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (lat_cnt == 4'd1) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            if (grant_i || grant_d) begin
                mem_en    <= 1'b1;
                mem_wr    <= win.wr;
                mem_addr  <= win.addr;
                mem_wdata <= win.wdata;
                lat_cnt   <= LAT_INIT;
                err       <= err | win.addr[0];
                // Counts only D wins that overtook a waiting fetch.
                if (grant_i || !i_req)
                    starve_cnt <= '0;
                else if (starve_cnt != STARVE_TOP)
                    starve_cnt <= starve_cnt + 1'b1;
            end else if (state != IDLE) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (finish) begin
                if (state == BUSY_I) begin
                    i_rdata <= mem_rdata;
                    i_done  <= 1'b1;
                end else begin
                    d_rdata <= mem_rdata;
                    d_done  <= 1'b1;
                end
            end
        end
    end

    assign fetch_stall = i_req & ~i_done;
    assign mem_stall   = d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked per cycle
// against a transaction-level model (grant cycle -> enable/done cycles, shadow memory).
module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int BIG        = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        i_done, d_done, mem_en, mem_wr, fetch_stall, mem_stall, err;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fetch_stall(fetch_stall), .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    // Memory device: read data valid only in the cycle after the enable cycle (MEM_LAT=2).
    logic [15:0] dev_mem [256];
    logic [15:0] rd_word = '0;
    bit          rd_valid = 1'b0;
    bit          dev_init = 1'b0;
    always @(posedge clk) begin
        if (!dev_init) begin
            for (int k = 0; k < 256; k++) dev_mem[k] <= 16'(k * 40503 + 7);
            dev_init <= 1'b1;
        end else begin
            rd_valid <= mem_en && !mem_wr;
            rd_word  <= dev_mem[mem_addr[8:1]];
            if (mem_en && mem_wr) dev_mem[mem_addr[8:1]] <= mem_wdata;
        end
    end
    assign mem_rdata = rd_valid ? rd_word : 16'h5A5A;

    int n_tests = 0, n_fail = 0;
    int n_idone = 0, n_ddone = 0;

    // Reference model state
    logic [15:0] ref_mem [256];
    int          cyc = 0, free_at = 0, en_cyc = -10, done_cyc = -10, err_cyc = BIG, starve = 0;
    bit          own_d = 1'b0, ex_wr = 1'b0, exp_id = 1'b0, exp_dd = 1'b0;
    logic [15:0] ex_addr = '0, ex_wdata = '0, ex_rdata = '0;
    int          p_keep_i = 0, p_new_i = 0, p_keep_d = 0, p_new_d = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic chk_zero_regs();
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_i_done", 32'(i_done), 32'd0);
        chk("rst_d_done", 32'(d_done), 32'd0);
        chk("rst_i_rdata", 32'(i_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    task automatic model_reset();
        free_at = 0; en_cyc = -10; done_cyc = -10; err_cyc = BIG; starve = 0;
    endtask

    task automatic new_d();
        d_wr    = 1'($urandom_range(1));
        d_addr  = ($urandom_range(3) == 0) ? 16'($urandom_range(31) * 2)
                                           : 16'h0100 + 16'($urandom_range(15) * 2);
        d_wdata = 16'($urandom);
    endtask

    // Check outputs of the current cycle, then let the requesters react.
    task automatic tick_check();
        @(negedge clk);
        exp_id = (cyc == done_cyc) && !own_d;
        exp_dd = (cyc == done_cyc) && own_d;
        chk("mem_en", 32'(mem_en), 32'(cyc == en_cyc));
        if (cyc == en_cyc) begin
            chk("mem_addr", 32'(mem_addr), 32'(ex_addr));
            chk("mem_wr", 32'(mem_wr), 32'(ex_wr));
            if (ex_wr) chk("mem_wdata", 32'(mem_wdata), 32'(ex_wdata));
        end
        if (cyc > en_cyc && cyc < done_cyc) chk("mem_addr_hold", 32'(mem_addr), 32'(ex_addr));
        chk("i_done", 32'(i_done), 32'(exp_id));
        chk("d_done", 32'(d_done), 32'(exp_dd));
        if (exp_id) chk("i_rdata", 32'(i_rdata), 32'(ex_rdata));
        if (exp_dd && !ex_wr) chk("d_rdata", 32'(d_rdata), 32'(ex_rdata));
        chk("err", 32'(err), 32'(cyc >= err_cyc));
        if (i_done) n_idone++;
        if (d_done) n_ddone++;

        if (i_req && exp_id) begin
            if ($urandom_range(99) < 32'(p_keep_i)) i_addr = i_addr + 16'd2;
            else i_req = 1'b0;
        end else if (!i_req && $urandom_range(99) < 32'(p_new_i)) begin
            i_req  = 1'b1;
            i_addr = 16'($urandom_range(31) * 2);
        end
        if (d_req && exp_dd) begin
            if ($urandom_range(99) < 32'(p_keep_d)) new_d();
            else d_req = 1'b0;
        end else if (!d_req && $urandom_range(99) < 32'(p_new_d)) begin
            d_req = 1'b1;
            new_d();
        end
    endtask

    // Check stalls on the final inputs and arbitrate this cycle in the model.
    task automatic tick_arb();
        bit pd;
        #1;
        chk("fetch_stall", 32'(fetch_stall), 32'(i_req && !exp_id));
        chk("mem_stall", 32'(mem_stall), 32'(d_req && !exp_dd));
        if (rst && cyc >= free_at && (i_req || d_req)) begin
            pd = d_req && !(i_req && starve == STARVE_MAX);
            if (pd && i_req) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else starve = 0;
            own_d    = pd;
            ex_addr  = pd ? d_addr : i_addr;
            ex_wr    = pd && d_wr;
            ex_wdata = d_wdata;
            if (ex_wr) ref_mem[ex_addr[8:1]] = d_wdata;
            else       ex_rdata = ref_mem[ex_addr[8:1]];
            en_cyc   = cyc + 1;
            done_cyc = cyc + MEM_LAT + 1;
            free_at  = done_cyc;
            if (ex_addr[0] && err_cyc > cyc + 1) err_cyc = cyc + 1;
        end
        cyc++;
    endtask

    task automatic step();
        tick_check();
        tick_arb();
    endtask

    initial begin
        int cnt0, guard;
        for (int k = 0; k < 256; k++) ref_mem[k] = 16'(k * 40503 + 7);

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero_regs();
        rst = 1'b1;
        cyc = 0;
        model_reset();

        // Single fetch
        tick_check(); i_req = 1'b1; i_addr = 16'h0010; tick_arb();
        repeat (6) step();

        // Contention: D write first, then I
        tick_check();
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        tick_arb();
        repeat (10) step();

        // Starvation: I held, D re-requests on every done
        p_keep_i = 100; p_keep_d = 100;
        tick_check(); i_req = 1'b1; i_addr = 16'h0040; d_req = 1'b1; new_d(); tick_arb();
        cnt0 = n_ddone; guard = 0;
        while (n_idone == 0 + n_idone - (n_idone - n_idone) && guard < 40) begin
            int id0;
            id0 = n_idone;
            step();
            guard++;
            if (n_idone != id0) break;
        end
        chk("starve_d_before_i", 32'(n_ddone - cnt0), 32'(STARVE_MAX));
        p_keep_i = 0; p_keep_d = 0;
        repeat (30) step();

        // Back-to-back fetch
        p_keep_i = 100;
        tick_check(); i_req = 1'b1; i_addr = 16'h0000; tick_arb();
        cnt0 = n_idone;
        repeat (14) step();
        chk("b2b_fetch_count", 32'(n_idone - cnt0), 32'd4);
        p_keep_i = 0;
        repeat (6) step();

        // Misaligned D read
        tick_check(); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0003; tick_arb();
        repeat (8) step();

        // Reset during a D access
        tick_check(); d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0104; tick_arb();
        step();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_zero_regs();
        d_req = 1'b0;
        model_reset();
        step();
        rst = 1'b1;
        repeat (3) step();
        tick_check(); i_req = 1'b1; i_addr = 16'h0030; tick_arb();
        repeat (6) step();

        // Random traffic
        p_keep_i = 70; p_new_i = 30; p_keep_d = 50; p_new_d = 25;
        repeat (1500) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
